access_arbiter_n: RTL and testbench

Parametrised, clocked successor to the two-station access-control datapath. It accepts access requests (user ID + function code) from N stations and arbitrates them round-robin. Each request is checked against a per-user permission table and rejected on duplicate identities. An accepted grant is held for a programmable dwell time. It sits between the station input decoders and the terminal output stage (matrix/LED/7-segment decoders), which consume the registered grant bus.

---
 rtl/access_arbiter_n.sv | 227 ++++++++++++++++++++++
 tb/tb_access_arbiter_n.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/access_arbiter_n.sv
// Round-robin access arbiter: N stations request (UID, function), each request is
// checked for duplicate identity and permission, and a grant is held for a fixed dwell.
// Optional audit counters are enabled by defining ACCESS_AUDIT_EN.
module access_arbiter_n #(
    parameter int N_STATIONS = 2,
    parameter int UID_W = 3,
    parameter int HOLD_CYCLES = 8,
    parameter logic [(2**UID_W)*7-1:0] PERM_TABLE = '1,
    localparam int STN_W = (N_STATIONS > 2) ? $clog2(N_STATIONS) : 1
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [N_STATIONS-1:0]       req_i,
    input  logic [N_STATIONS*UID_W-1:0] uid_i,
    input  logic [N_STATIONS*3-1:0]     func_i,
    output logic [N_STATIONS-1:0]       ack_o,
    output logic                        gnt_valid_o,
    output logic [STN_W-1:0]            gnt_stn_o,
    output logic [UID_W-1:0]            gnt_uid_o,
    output logic [2:0]                  gnt_func_o,
    output logic                        deny_o,
    output logic [1:0]                  deny_code_o,
    output logic [7:0]                  deny_cnt_o,
    output logic [UID_W-1:0]            last_deny_uid_o
);

    typedef enum logic [1:0] {
        IDLE,
        EVAL,
        HOLD
    } state_t;

    localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);

    state_t                  state_q, state_d;
    logic [STN_W-1:0]        ptr_q, ptr_d;
    logic [STN_W-1:0]        win_q, win_d;
    logic [UID_W-1:0]        uidLat_q, uidLat_d;
    logic [2:0]              funcLat_q, funcLat_d;
    logic [7:0]              cnt_q, cnt_d;
    logic [N_STATIONS-1:0]   arm_q, arm_d;
    logic [N_STATIONS-1:0]   ack_q, ack_d;
    logic                    gntValid_q, gntValid_d;
    logic [STN_W-1:0]        gntStn_q, gntStn_d;
    logic [UID_W-1:0]        gntUid_q, gntUid_d;
    logic [2:0]              gntFunc_q, gntFunc_d;
    logic                    deny_q, deny_d;
    logic [1:0]              denyCode_q, denyCode_d;

    logic [N_STATIONS-1:0]   pending;
    logic                    found;
    logic [STN_W-1:0]        winIdx;
    int                      searchIdx;
    logic [N_STATIONS-1:0]   dupMask;
    logic [N_STATIONS-1:0]   winOneHot;
    logic                    permOk;
    logic [STN_W-1:0]        ptrNext;

    // A station only counts once per REQ assertion: the arm bit re-opens on a sampled low.
    assign pending = req_i & arm_q;

    always_comb begin
        found     = 1'b0;
        winIdx    = '0;
        searchIdx = 0;
        for (int off = 0; off < N_STATIONS; off++) begin
            searchIdx = int'(ptr_q) + off;
            if (searchIdx >= N_STATIONS) begin
                searchIdx = searchIdx - N_STATIONS;
            end
            if (!found && pending[searchIdx[STN_W-1:0]]) begin
                found  = 1'b1;
                winIdx = searchIdx[STN_W-1:0];
            end
        end
    end

    // Duplicate check uses the live UIDs of the other pending stations at evaluation time.
    always_comb begin
        dupMask = '0;
        for (int j = 0; j < N_STATIONS; j++) begin
            if (j != int'(win_q) && pending[j] &&
                uid_i[j*UID_W +: UID_W] == uidLat_q) begin
                dupMask[j] = 1'b1;
            end
        end
    end

    always_comb begin
        permOk = 1'b0;
        if (funcLat_q != 3'd0) begin
            permOk = PERM_TABLE[int'(uidLat_q)*7 + int'(funcLat_q) - 1];
        end
    end

    assign winOneHot = {{(N_STATIONS-1){1'b0}}, 1'b1} << win_q;
    assign ptrNext   = (int'(win_q) == N_STATIONS - 1) ? '0 : win_q + STN_W'(1);

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        win_d      = win_q;
        uidLat_d   = uidLat_q;
        funcLat_d  = funcLat_q;
        cnt_d      = cnt_q;
        ack_d      = '0;
        gntValid_d = gntValid_q;
        gntStn_d   = gntStn_q;
        gntUid_d   = gntUid_q;
        gntFunc_d  = gntFunc_q;
        deny_d     = 1'b0;
        denyCode_d = denyCode_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    win_d     = winIdx;
                    uidLat_d  = uid_i[int'(winIdx)*UID_W +: UID_W];
                    funcLat_d = func_i[int'(winIdx)*3 +: 3];
                    state_d   = EVAL;
                end
            end
            EVAL: begin
                ptr_d   = ptrNext;
                state_d = IDLE;
                if (|dupMask) begin
                    ack_d      = winOneHot | dupMask;
                    deny_d     = 1'b1;
                    denyCode_d = 2'b10;
                end else if (funcLat_q == 3'd0) begin
                    ack_d      = winOneHot;
                    deny_d     = 1'b1;
                    denyCode_d = 2'b11;
                end else if (!permOk) begin
                    ack_d      = winOneHot;
                    deny_d     = 1'b1;
                    denyCode_d = 2'b01;
                end else begin
                    ack_d      = winOneHot;
                    gntValid_d = 1'b1;
                    gntStn_d   = win_q;
                    gntUid_d   = uidLat_q;
                    gntFunc_d  = funcLat_q;
                    cnt_d      = HOLD_LOAD;
                    state_d    = HOLD;
                end
            end
            HOLD: begin
                if (cnt_q == 8'd0) begin
                    gntValid_d = 1'b0;
                    state_d    = IDLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign arm_d = (arm_q | ~req_i) & ~ack_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            win_q      <= '0;
            uidLat_q   <= '0;
            funcLat_q  <= '0;
            cnt_q      <= '0;
            arm_q      <= '1;
            ack_q      <= '0;
            gntValid_q <= 1'b0;
            gntStn_q   <= '0;
            gntUid_q   <= '0;
            gntFunc_q  <= '0;
            deny_q     <= 1'b0;
            denyCode_q <= 2'b00;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            win_q      <= win_d;
            uidLat_q   <= uidLat_d;
            funcLat_q  <= funcLat_d;
            cnt_q      <= cnt_d;
            arm_q      <= arm_d;
            ack_q      <= ack_d;
            gntValid_q <= gntValid_d;
            gntStn_q   <= gntStn_d;
            gntUid_q   <= gntUid_d;
            gntFunc_q  <= gntFunc_d;
            deny_q     <= deny_d;
            denyCode_q <= denyCode_d;
        end
    end

    assign ack_o       = ack_q;
    assign gnt_valid_o = gntValid_q;
    assign gnt_stn_o   = gntStn_q;
    assign gnt_uid_o   = gntUid_q;
    assign gnt_func_o  = gntFunc_q;
    assign deny_o      = deny_q;
    assign deny_code_o = denyCode_q;

`ifdef ACCESS_AUDIT_EN
    logic [7:0]       denyCnt_q;
    logic [UID_W-1:0] lastDenyUid_q;

    // Audit registers update on the same edge that raises DENY so they are visible with it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            denyCnt_q     <= '0;
            lastDenyUid_q <= '0;
        end else if (deny_d) begin
            if (denyCnt_q != 8'hFF) begin
                denyCnt_q <= denyCnt_q + 8'd1;
            end
            lastDenyUid_q <= uidLat_q;
        end
    end

    assign deny_cnt_o      = denyCnt_q;
    assign last_deny_uid_o = lastDenyUid_q;
`else
    assign deny_cnt_o      = 8'd0;
    assign last_deny_uid_o = '0;
`endif

endmodule

// File: tb/tb_access_arbiter_n.sv
// Directed self-checking bench for access_arbiter_n (4 stations, 4-cycle hold,
// uid2/func2 and all of uid7 forbidden). Audit expectations follow ACCESS_AUDIT_EN.
module tb_access_arbiter_n;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [11:0] uidIn;
    logic [11:0] funcIn;
    logic [3:0]  ack;
    logic        gntValid;
    logic [1:0]  gntStn;
    logic [2:0]  gntUid;
    logic [2:0]  gntFunc;
    logic        deny;
    logic [1:0]  denyCode;
    logic [7:0]  denyCnt;
    logic [2:0]  lastDenyUid;

    int total = 0;
    int bad = 0;

`ifdef ACCESS_AUDIT_EN
    localparam bit AUDIT = 1'b1;
`else
    localparam bit AUDIT = 1'b0;
`endif

    access_arbiter_n #(
        .N_STATIONS (4),
        .UID_W      (3),
        .HOLD_CYCLES(4),
        .PERM_TABLE (56'h01_FFFF_FFFF_7FFF)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .req_i          (req),
        .uid_i          (uidIn),
        .func_i         (funcIn),
        .ack_o          (ack),
        .gnt_valid_o    (gntValid),
        .gnt_stn_o      (gntStn),
        .gnt_uid_o      (gntUid),
        .gnt_func_o     (gntFunc),
        .deny_o         (deny),
        .deny_code_o    (denyCode),
        .deny_cnt_o     (denyCnt),
        .last_deny_uid_o(lastDenyUid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setStation(input int s, input logic [2:0] u, input logic [2:0] f);
        uidIn[s*3 +: 3]  = u;
        funcIn[s*3 +: 3] = f;
    endtask

    task automatic doReset();
        rst = 1'b1;
        req = 4'b0000;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 4'b0000;
        tick();
        tick();
        total++; if (ack !== 4'b0000) begin bad++; $display("[TB] FAIL reset_ack: got %b expected 0000", ack); end
        total++; if (gntValid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid: got %b expected 0", gntValid); end
        total++; if ({gntStn, gntUid, gntFunc} !== 8'h00) begin bad++; $display("[TB] FAIL reset_gnt: got %h expected 00", {gntStn, gntUid, gntFunc}); end
        total++; if ({deny, denyCode} !== 3'b000) begin bad++; $display("[TB] FAIL reset_deny: got %b expected 000", {deny, denyCode}); end
        total++; if ({denyCnt, lastDenyUid} !== 11'h000) begin bad++; $display("[TB] FAIL reset_audit: got %h expected 000", {denyCnt, lastDenyUid}); end
        rst = 1'b0;
    endtask

    task automatic test_single_grant();
        doReset();
        setStation(0, 3'd5, 3'd3);
        req = 4'b0001;
        tick();
        total++; if (ack !== 4'b0000) begin bad++; $display("[TB] FAIL sg_latch_ack: got %b expected 0000", ack); end
        tick();
        total++; if (ack !== 4'b0001) begin bad++; $display("[TB] FAIL sg_ack: got %b expected 0001", ack); end
        total++; if (gntValid !== 1'b1) begin bad++; $display("[TB] FAIL sg_valid: got %b expected 1", gntValid); end
        total++; if (gntStn !== 2'd0 || gntUid !== 3'd5 || gntFunc !== 3'd3) begin bad++; $display("[TB] FAIL sg_fields: got stn=%0d uid=%0d func=%0d expected 0 5 3", gntStn, gntUid, gntFunc); end
        total++; if (deny !== 1'b0) begin bad++; $display("[TB] FAIL sg_deny: got %b expected 0", deny); end
        for (int c = 1; c < 4; c++) begin
            tick();
            total++; if (gntValid !== 1'b1 || ack !== 4'b0000) begin bad++; $display("[TB] FAIL sg_hold%0d: got valid=%b ack=%b expected 1 0000", c, gntValid, ack); end
        end
        tick();
        total++; if (gntValid !== 1'b0) begin bad++; $display("[TB] FAIL sg_release: got %b expected 0", gntValid); end
        total++; if (gntUid !== 3'd5 || gntFunc !== 3'd3) begin bad++; $display("[TB] FAIL sg_retain: got uid=%0d func=%0d expected 5 3", gntUid, gntFunc); end
        for (int c = 0; c < 3; c++) begin
            tick();
            total++; if (ack !== 4'b0000 || gntValid !== 1'b0) begin bad++; $display("[TB] FAIL sg_no_retrigger%0d: got ack=%b valid=%b expected 0000 0", c, ack, gntValid); end
        end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_back_to_back();
        doReset();
        setStation(0, 3'd5, 3'd3);
        setStation(1, 3'd3, 3'd1);
        req = 4'b0001;
        tick();
        tick();
        req = 4'b0011;
        for (int c = 0; c < 3; c++) begin
            tick();
            total++; if (ack !== 4'b0000 || gntValid !== 1'b1) begin bad++; $display("[TB] FAIL b2b_wait%0d: got ack=%b valid=%b expected 0000 1", c, ack, gntValid); end
        end
        tick();
        total++; if (gntValid !== 1'b0) begin bad++; $display("[TB] FAIL b2b_exit: got %b expected 0", gntValid); end
        tick();
        total++; if (gntValid !== 1'b0 || ack !== 4'b0000) begin bad++; $display("[TB] FAIL b2b_idle: got valid=%b ack=%b expected 0 0000", gntValid, ack); end
        tick();
        total++; if (ack !== 4'b0010 || gntValid !== 1'b1 || gntStn !== 2'd1 || gntUid !== 3'd3 || gntFunc !== 3'd1) begin bad++; $display("[TB] FAIL b2b_grant: got ack=%b valid=%b stn=%0d uid=%0d func=%0d expected 0010 1 1 3 1", ack, gntValid, gntStn, gntUid, gntFunc); end
        req = 4'b0000;
        for (int c = 0; c < 5; c++) tick();
    endtask

    task automatic test_perm_deny();
        doReset();
        setStation(1, 3'd2, 3'd2);
        req = 4'b0010;
        tick();
        tick();
        total++; if (ack !== 4'b0010 || deny !== 1'b1) begin bad++; $display("[TB] FAIL perm_ack: got ack=%b deny=%b expected 0010 1", ack, deny); end
        total++; if (denyCode !== 2'b01 || gntValid !== 1'b0) begin bad++; $display("[TB] FAIL perm_code: got code=%b valid=%b expected 01 0", denyCode, gntValid); end
        total++; if (denyCnt !== (AUDIT ? 8'd1 : 8'd0) || lastDenyUid !== (AUDIT ? 3'd2 : 3'd0)) begin bad++; $display("[TB] FAIL perm_audit: got cnt=%0d uid=%0d expected %0d %0d", denyCnt, lastDenyUid, AUDIT ? 1 : 0, AUDIT ? 2 : 0); end
        tick();
        total++; if (deny !== 1'b0 || denyCode !== 2'b01 || ack !== 4'b0000) begin bad++; $display("[TB] FAIL perm_after: got deny=%b code=%b ack=%b expected 0 01 0000", deny, denyCode, ack); end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_dup();
        doReset();
        setStation(0, 3'd6, 3'd1);
        setStation(1, 3'd6, 3'd1);
        req = 4'b0011;
        tick();
        tick();
        total++; if (ack !== 4'b0011 || deny !== 1'b1 || denyCode !== 2'b10) begin bad++; $display("[TB] FAIL dup: got ack=%b deny=%b code=%b expected 0011 1 10", ack, deny, denyCode); end
        total++; if (gntValid !== 1'b0) begin bad++; $display("[TB] FAIL dup_valid: got %b expected 0", gntValid); end
        for (int c = 0; c < 3; c++) tick();
        total++; if (ack !== 4'b0000 || gntValid !== 1'b0 || deny !== 1'b0) begin bad++; $display("[TB] FAIL dup_quiet: got ack=%b valid=%b deny=%b expected 0000 0 0", ack, gntValid, deny); end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_no_func();
        doReset();
        setStation(0, 3'd7, 3'd0);
        req = 4'b0001;
        tick();
        tick();
        total++; if (ack !== 4'b0001 || deny !== 1'b1 || denyCode !== 2'b11) begin bad++; $display("[TB] FAIL no_func: got ack=%b deny=%b code=%b expected 0001 1 11", ack, deny, denyCode); end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_round_robin();
        int exp;
        doReset();
        for (int s = 0; s < 4; s++) setStation(s, 3'(s), 3'd1);
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            exp = i % 4;
            tick();
            tick();
            total++; if (ack !== (4'b0001 << exp) || gntStn !== 2'(exp) || gntValid !== 1'b1) begin bad++; $display("[TB] FAIL rr%0d: got ack=%b stn=%0d valid=%b expected stn %0d", i, ack, gntStn, gntValid, exp); end
            req[exp] = 1'b0;
            tick();
            req[exp] = 1'b1;
            tick();
            tick();
            tick();
            total++; if (gntValid !== 1'b0) begin bad++; $display("[TB] FAIL rr_end%0d: got %b expected 0", i, gntValid); end
        end
        req = 4'b0000;
        for (int c = 0; c < 6; c++) tick();
    endtask

    task automatic test_deny_saturation();
        int denies = 0;
        doReset();
        setStation(0, 3'd7, 3'd1);
        for (int i = 0; i < 300; i++) begin
            req = 4'b0001;
            tick();
            tick();
            if (deny === 1'b1 && denyCode === 2'b01) denies++;
            req = 4'b0000;
            tick();
        end
        total++; if (denies != 300) begin bad++; $display("[TB] FAIL sat_pulses: got %0d expected 300", denies); end
        total++; if (denyCnt !== (AUDIT ? 8'd255 : 8'd0)) begin bad++; $display("[TB] FAIL sat_cnt: got %0d expected %0d", denyCnt, AUDIT ? 255 : 0); end
        total++; if (lastDenyUid !== (AUDIT ? 3'd7 : 3'd0)) begin bad++; $display("[TB] FAIL sat_uid: got %0d expected %0d", lastDenyUid, AUDIT ? 7 : 0); end
    endtask

    task automatic test_reset_mid_hold();
        doReset();
        setStation(0, 3'd5, 3'd3);
        setStation(1, 3'd4, 3'd1);
        req = 4'b0011;
        tick();
        tick();
        total++; if (gntValid !== 1'b1 || gntStn !== 2'd0) begin bad++; $display("[TB] FAIL rmh_first: got valid=%b stn=%0d expected 1 0", gntValid, gntStn); end
        tick();
        rst = 1'b1;
        tick();
        total++; if (ack !== 4'b0000 || gntValid !== 1'b0 || {gntStn, gntUid, gntFunc} !== 8'h00 || deny !== 1'b0 || denyCode !== 2'b00 || denyCnt !== 8'd0 || lastDenyUid !== 3'd0) begin bad++; $display("[TB] FAIL rmh_reset: got ack=%b valid=%b gnt=%h deny=%b code=%b cnt=%0d uid=%0d expected all 0", ack, gntValid, {gntStn, gntUid, gntFunc}, deny, denyCode, denyCnt, lastDenyUid); end
        rst = 1'b0;
        tick();
        total++; if (ack !== 4'b0000) begin bad++; $display("[TB] FAIL rmh_latch: got %b expected 0000", ack); end
        tick();
        total++; if (ack !== 4'b0001 || gntValid !== 1'b1 || gntStn !== 2'd0 || gntUid !== 3'd5) begin bad++; $display("[TB] FAIL rmh_regrant: got ack=%b valid=%b stn=%0d uid=%0d expected 0001 1 0 5", ack, gntValid, gntStn, gntUid); end
        req = 4'b0000;
        for (int c = 0; c < 5; c++) tick();
    endtask

    initial begin
        rst    = 1'b1;
        req    = 4'b0000;
        uidIn  = '0;
        funcIn = '0;
        test_reset();
        test_single_grant();
        test_back_to_back();
        test_perm_deny();
        test_dup();
        test_no_func();
        test_round_robin();
        test_deny_saturation();
        test_reset_mid_hold();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
